// File: rtl/fb_ram_arbiter.sv
// Purpose : shares framebuffer RAM port A between two requesters (round-robin),
//           with an optional whole-RAM clear engine (enabled by FB_ARB_CLEAR_EN).
// Latency : grant is combinational (0 cycles); read data/rvalid one cycle after the transfer.
// Backpr. : a requester without gnt must hold req/we/addr/wdata; during a clear no grants are given.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req*/we*/addr*/wdata*      requester 0/1 access request (we=1 write, 0 read)
//   gnt*                       combinational grant; transfer happens on the edge where req & gnt
//   rvalid*/rdata*             registered read-valid strobe; rdata is the RAM output
//   clr_start/clr_value        start a fill of the whole RAM with clr_value (IDLE only)
//   clr_busy/clr_done          clear in progress / one-cycle completion pulse
//   ram_we/ram_addr/ram_din    to RAM port A; ram_dout from RAM port A (1-cycle read)
// Build option: define FB_ARB_CLEAR_EN to include the clear engine; otherwise the
// block is a pure round-robin arbiter and clr_busy/clr_done are tied low.
module fb_ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_value,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  // Index of the requester granted most recently; the other one wins a tie.
  logic                  last;
  logic                  in_clear;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] clr_data;

`ifdef FB_ARB_CLEAR_EN
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] clr_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_val  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_val  <= clr_value;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          // Last address written this cycle: leave without wrapping the counter.
          if (clr_cnt == CNT_LAST) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_clear = (state == CLEAR);
  assign clr_addr = clr_cnt;
  assign clr_data = clr_val;
`else
  logic unused_clr;

  assign unused_clr = ^{clr_start, clr_value};
  assign in_clear   = 1'b0;
  assign clr_addr   = '0;
  assign clr_data   = '0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
`endif

  // Round-robin: on contention the requester that was not granted last wins.
  assign gnt0 = ~in_clear & req0 & (~req1 | last);
  assign gnt1 = ~in_clear & req1 & (~req0 | ~last);

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (in_clear) begin
      ram_we   = 1'b1;
      ram_addr = clr_addr;
      ram_din  = clr_data;
    end else if (gnt0) begin
      ram_we   = we0;
      ram_addr = addr0;
      ram_din  = wdata0;
    end else if (gnt1) begin
      ram_we   = we1;
      ram_addr = addr1;
      ram_din  = wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      if (gnt0) begin
        last <= 1'b0;
      end else if (gnt1) begin
        last <= 1'b1;
      end
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end

  // RAM read data is passed straight through; rvalid qualifies it.
  assign rdata0 = ram_dout;
  assign rdata1 = ram_dout;

endmodule

// File: tb/tb_fb_ram_arbiter.sv
module tb_fb_ram_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          clr_start;
  logic [DW-1:0] clr_value;
  logic          clr_busy, clr_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  fb_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .clr_start(clr_start), .clr_value(clr_value),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Port A of the framebuffer RAM: synchronous, read-before-write.
  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard state
  logic [DW-1:0] shadow [N];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          pend0 = 1'b0;
  logic          pend1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 after inputs are driven; moves to the negedge, checks
  // grants and any pending read result, and records what the grants imply.
  task automatic cyc_chk(input logic eg0, input logic eg1);
    logic [DW-1:0] e;
    #4;
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    chk("rvalid0", rvalid0, pend0);
    if (pend0) begin e = q0.pop_front(); chk("rdata0", rdata0, e); end
    chk("rvalid1", rvalid1, pend1);
    if (pend1) begin e = q1.pop_front(); chk("rdata1", rdata1, e); end
    pend0 = eg0 && !we0;
    pend1 = eg1 && !we1;
    if (pend0) q0.push_back(shadow[addr0]);
    if (pend1) q1.push_back(shadow[addr1]);
    if (eg0 && we0) shadow[addr0] = wdata0;
    if (eg1 && we1) shadow[addr1] = wdata1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    clr_start = 0; clr_value = '0;
  endtask

  task automatic sb_clear();
    pend0 = 0; pend1 = 0;
    q0.delete(); q1.delete();
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    nxt(); nxt();
    rst_n = 1;
    sb_clear();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    #12;
    // Reset state
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Single requester: write then read addr 3
    req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 8'h5A;
    cyc_chk(1, 0);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 3);
    chk("wr_ram_din", ram_din, 8'h5A);
    nxt();
    we0 = 0; wdata0 = '0;
    cyc_chk(1, 0);
    chk("rd_ram_we", ram_we, 0);
    nxt();
    idle_inputs();
    cyc_chk(0, 0);
    chk("idle_ram_addr", ram_addr, 0);
    chk("idle_ram_din", ram_din, 0);
    nxt();

    // Contention from reset: req0 reads addr 3, req1 writes addr 7
    do_reset();
    req0 = 1; we0 = 0; addr0 = 4'd3;
    req1 = 1; we1 = 1; addr1 = 4'd7; wdata1 = 8'h3C;
    cyc_chk(1, 0); nxt();
    cyc_chk(0, 1); chk("ct_ram_din", ram_din, 8'h3C); nxt();
    cyc_chk(1, 0); nxt();
    cyc_chk(0, 1); nxt();
    idle_inputs();
    cyc_chk(0, 0); nxt();
    chk("mem7", mem[7], 8'h3C);

`ifdef FB_ARB_CLEAR_EN
    // Clear with 0xFF; req1 arrives at clear cycle 2, restart pulse at cycle 8
    clr_start = 1; clr_value = 8'hFF;
    cyc_chk(0, 0);
    chk("clr_k_busy", clr_busy, 0);
    nxt();
    clr_start = 0; clr_value = '0;
    for (int i = 1; i <= N; i++) begin
      if (i == 2) begin req1 = 1; we1 = 0; addr1 = 4'd9; end
      if (i == 8) begin clr_start = 1; clr_value = 8'h00; end
      if (i == 9) clr_start = 0;
      cyc_chk(0, 0);
      chk("clr_busy", clr_busy, 1);
      chk("clr_done", clr_done, 0);
      chk("clr_ram_we", ram_we, 1);
      chk("clr_ram_addr", ram_addr, i - 1);
      chk("clr_ram_din", ram_din, 8'hFF);
      nxt();
    end
    for (int a = 0; a < N; a++) shadow[a] = 8'hFF;
    cyc_chk(0, 1);
    chk("done_pulse", clr_done, 1);
    chk("done_busy", clr_busy, 0);
    nxt();
    idle_inputs();
    cyc_chk(0, 0);
    chk("done_once", clr_done, 0);
    chk("post_busy", clr_busy, 0);
    nxt();
    for (int a = 0; a < N; a++) chk("mem_clr", mem[a], 8'hFF);

    // Reset mid-clear
    clr_start = 1; clr_value = 8'h11;
    cyc_chk(0, 0);
    nxt();
    clr_start = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc_chk(0, 0);
      chk("clr2_busy", clr_busy, 1);
      if (i < 5) nxt();
    end
    rst_n = 0;
    #1;
    chk("abort_busy", clr_busy, 0);
    chk("abort_done", clr_done, 0);
    chk("abort_rvalid0", rvalid0, 0);
    chk("abort_rvalid1", rvalid1, 0);
    sb_clear();
    nxt();
    rst_n = 1;
    req0 = 1; we0 = 0; addr0 = 4'd9;
    req1 = 1; we1 = 0; addr1 = 4'd12;
    cyc_chk(1, 0); nxt();
    cyc_chk(0, 1); nxt();
    idle_inputs();
    cyc_chk(0, 0); nxt();
`else
    // Clear engine absent: clr_start ignored, requester served immediately
    clr_start = 1; clr_value = 8'hAA;
    req0 = 1; we0 = 1; addr0 = 4'd5; wdata0 = 8'hC3;
    cyc_chk(1, 0);
    chk("nc_busy", clr_busy, 0);
    chk("nc_done", clr_done, 0);
    chk("nc_ram_din", ram_din, 8'hC3);
    nxt();
    clr_start = 0;
    we0 = 0;
    cyc_chk(1, 0);
    chk("nc_busy2", clr_busy, 0);
    chk("nc_done2", clr_done, 0);
    nxt();
    idle_inputs();
    cyc_chk(0, 0);
    chk("nc_busy3", clr_busy, 0);
    nxt();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
